word_shift_packer: RTL and testbench



---
 rtl/word_shift_pkg.sv | 25 ++
 rtl/word_shift_out_reg.sv | 43 ++++
 rtl/word_shift_packer.sv | 135 +++++++++++++
 tb/tb_word_shift_packer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/word_shift_pkg.sv
// +--------------------------------------------------------------------+
// | Module   : word_shift_pkg                                          |
// | Brief    : Shared types, limits and helpers for the word-shift path |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
`default_nettype none

package word_shift_pkg;

    typedef logic [7:0] byte_t;

    localparam int WORD_BYTES_MAX = 8;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_e;

    function automatic logic even_parity8(input byte_t b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/word_shift_out_reg.sv
// +--------------------------------------------------------------------+
// | Module   : word_shift_out_reg                                      |
// | Brief    : Single-entry valid/ready output register                |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module word_shift_out_reg #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [PAYLOAD_W-1:0] i_payload,
    input  logic                 i_out_ready,
    output logic                 o_slot_free,
    output logic                 o_out_valid,
    output logic [PAYLOAD_W-1:0] o_payload
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;

    assign o_slot_free = !r_valid || i_out_ready;
    assign o_out_valid = r_valid;
    assign o_payload   = r_payload;

    // Payload only changes on load, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_payload <= i_payload;
        end else if (i_out_ready) begin
            r_valid   <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/word_shift_packer.sv
// +--------------------------------------------------------------------+
// | Module   : word_shift_packer                                       |
// | Brief    : Packs shifted bytes into PACK_N-byte valid/ready words;  |
// |            optional per-lane parity via WORD_PACK_PARITY_EN.       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module word_shift_packer
    import word_shift_pkg::*;
#(
    parameter  int PACK_N = 4,
    localparam int CW     = $clog2(PACK_N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*PACK_N-1:0]   out_data,
    output logic [CW-1:0]         out_count,
    output logic                  out_last
`ifdef WORD_PACK_PARITY_EN
    ,
    output logic [PACK_N-1:0]     out_parity
`endif
);

    localparam int c_DATA_W = 8 * PACK_N;
`ifdef WORD_PACK_PARITY_EN
    localparam int c_PAY_W  = 1 + CW + c_DATA_W + PACK_N;
`else
    localparam int c_PAY_W  = 1 + CW + c_DATA_W;
`endif

    pack_state_e         r_state;
    pack_state_e         w_state_nxt;
    logic [c_DATA_W-1:0] r_acc;
    logic [CW-1:0]       r_acc_cnt;
    logic                r_flush_pend;

    logic                w_accept;
    logic [CW-1:0]       w_n;
    logic [c_DATA_W-1:0] w_acc_new;
    logic                w_flush_close;
    logic                w_close;
    logic                w_load;
    logic                w_slot_free;
    logic [c_PAY_W-1:0]  w_load_payload;
    logic [c_PAY_W-1:0]  w_out_payload;

    // FILL is exactly (acc_cnt < PACK_N && !flush_pend).
    assign in_ready = (r_state == ST_FILL);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_acc_new = r_acc;
        for (int i = 0; i < PACK_N; i++) begin
            if (w_accept && (r_acc_cnt == CW'(i))) begin
                w_acc_new[8*i +: 8] = in_data;
            end
        end
    end

    // Close decisions use the post-accept count; a full word is never a flush close.
    assign w_n           = r_acc_cnt + CW'(w_accept);
    assign w_flush_close = (flush || r_flush_pend) && (w_n != '0) && (w_n < CW'(PACK_N));
    assign w_close       = (w_n == CW'(PACK_N)) || w_flush_close;
    assign w_load        = w_close && w_slot_free;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: if (w_close && !w_slot_free) w_state_nxt = ST_HOLD;
            ST_HOLD: if (w_slot_free)             w_state_nxt = ST_FILL;
            default:                              w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_acc        <= '0;
            r_acc_cnt    <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_acc        <= '0;
                r_acc_cnt    <= '0;
                r_flush_pend <= 1'b0;
            end else begin
                r_acc        <= w_acc_new;
                r_acc_cnt    <= w_n;
                r_flush_pend <= r_flush_pend || w_flush_close;
            end
        end
    end

`ifdef WORD_PACK_PARITY_EN
    logic [PACK_N-1:0] w_parity;

    always_comb begin
        w_parity = '0;
        for (int i = 0; i < PACK_N; i++) begin
            w_parity[i] = even_parity8(w_acc_new[8*i +: 8]);
        end
    end

    assign w_load_payload = {w_flush_close, w_n, w_acc_new, w_parity};
    assign {out_last, out_count, out_data, out_parity} = w_out_payload;
`else
    assign w_load_payload = {w_flush_close, w_n, w_acc_new};
    assign {out_last, out_count, out_data} = w_out_payload;
`endif

    word_shift_out_reg #(
        .PAYLOAD_W (c_PAY_W)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_payload   (w_load_payload),
        .i_out_ready (out_ready),
        .o_slot_free (w_slot_free),
        .o_out_valid (out_valid),
        .o_payload   (w_out_payload)
    );

endmodule

`default_nettype wire

// File: tb/tb_word_shift_packer.sv
// +--------------------------------------------------------------------+
// | Module   : tb_word_shift_packer                                    |
// | Brief    : Directed self-checking bench for word_shift_packer      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_word_shift_packer;

    localparam int PACK_N = 4;
    localparam int CW     = $clog2(PACK_N + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_data;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [8*PACK_N-1:0] out_data;
    logic [CW-1:0]       out_count;
    logic                out_last;
`ifdef WORD_PACK_PARITY_EN
    logic [PACK_N-1:0]   out_parity;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    word_shift_packer #(.PACK_N(PACK_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_last   (out_last)
`ifdef WORD_PACK_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
    endtask

    task automatic check_word(input string tag, input logic [31:0] data,
                              input logic [CW-1:0] cnt, input logic last);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"},  64'(out_data),  64'(data));
        check({tag, "_count"}, 64'(out_count), 64'(cnt));
        check({tag, "_last"},  64'(out_last),  64'(last));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        step(); step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        rst = 1'b0;
        step();

        // Full word with free output
        for (int i = 0; i < 4; i++) begin
            check("t1_in_ready", 64'(in_ready), 64'd1);
            send_byte(8'h11 * (i + 1));
        end
        in_valid = 1'b0;
        check_word("t1", 32'h44332211, 3'd4, 1'b0);
        check("t1_in_ready_after", 64'(in_ready), 64'd1);
        step();
        check("t1_drain", 64'(out_valid), 64'd0);

        // Partial word closed by flush, then an empty flush
        send_byte(8'hA1);
        send_byte(8'hB2);
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_word("t2", 32'h0000B2A1, 3'd2, 1'b1);
        step();
        check("t2_drain", 64'(out_valid), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t2_empty_flush_a", 64'(out_valid), 64'd0);
        step();
        check("t2_empty_flush_b", 64'(out_valid), 64'd0);

        // Backpressure: two words, second held in the accumulator
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check("t3_in_ready", 64'(in_ready), 64'd1);
            send_byte(8'(i));
        end
        in_valid = 1'b0;
        check("t3_in_ready_full", 64'(in_ready), 64'd0);
        check_word("t3_hold", 32'h04030201, 3'd4, 1'b0);
        step();
        check_word("t3_stable", 32'h04030201, 3'd4, 1'b0);
        out_ready = 1'b1;
        step();
        check_word("t3_second", 32'h08070605, 3'd4, 1'b0);
        check("t3_in_ready_back", 64'(in_ready), 64'd1);
        step();
        check("t3_drain", 64'(out_valid), 64'd0);

        // Byte and flush in the same cycle from empty
        in_valid = 1'b1; in_data = 8'h5C; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check_word("t4", 32'h0000005C, 3'd1, 1'b1);
        step();

        // Flush together with the byte that fills the word is an ordinary word
        send_byte(8'hD1);
        send_byte(8'hD2);
        send_byte(8'hD3);
        flush = 1'b1;
        send_byte(8'hD4);
        flush = 1'b0; in_valid = 1'b0;
        check_word("t4b", 32'hD4D3D2D1, 3'd4, 1'b0);
        step();

        // Reset mid-word with a stalled output
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        for (int i = 0; i < 3; i++) send_byte(8'h21 + 8'(i));
        in_valid = 1'b0;
        check("t5_stalled", 64'(out_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_valid",    64'(out_valid), 64'd0);
        check("t5_rst_in_ready", 64'(in_ready),  64'd1);
        check("t5_rst_data",     64'(out_data),  64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hC1 + 8'(i));
            in_valid = 1'b0;
            check("t5_no_early_word", 64'(out_valid), 64'd0);
        end
        send_byte(8'hC4);
        in_valid = 1'b0;
        check_word("t5_clean", 32'hC4C3C2C1, 3'd4, 1'b0);
        step();

`ifdef WORD_PACK_PARITY_EN
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h07);
        send_byte(8'h00);
        in_valid = 1'b0;
        check_word("t6", 32'h00070301, 3'd4, 1'b0);
        check("t6_parity", 64'(out_parity), 64'b0101);
        step();
        send_byte(8'h07);
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("t6_parity_unused", 64'(out_parity), 64'b0001);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
